// File: rtl/lsu_pkg.sv
// Shared encodings and request-check helper for the load/store unit.
package lsu_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_READ  = 2'd1;
    localparam logic [1:0] ST_WRITE = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
        case (size)
            SZ_HALF: is_misaligned = offset[0];
            SZ_WORD: is_misaligned = (offset != 2'b00);
            default: is_misaligned = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_lane_unit.sv
// Little-endian byte-lane merge for sub-word stores and extract/extend for loads.
module lsu_lane_unit
    import lsu_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [31:0] wdata_i,
    input  logic [1:0]  size_i,
    input  logic [1:0]  offset_i,
    input  logic        unsigned_i,
    output logic [31:0] merged_word_o,
    output logic [31:0] load_value_o
);

    logic [4:0]  byte_base;
    logic [4:0]  half_base;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign byte_base = {offset_i, 3'b000};
    assign half_base = {offset_i[1], 4'b0000};
    assign byte_sel  = word_i[byte_base +: 8];
    assign half_sel  = word_i[half_base +: 16];

    always_comb begin
        // NOTE: every output gets a default before the case so no path infers a latch.
        merged_word_o = word_i;
        load_value_o  = word_i;
        case (size_i)
            SZ_BYTE: begin
                merged_word_o[byte_base +: 8] = wdata_i[7:0];
                load_value_o = {{24{~unsigned_i & byte_sel[7]}}, byte_sel};
            end
            SZ_HALF: begin
                merged_word_o[half_base +: 16] = wdata_i[15:0];
                load_value_o = {{16{~unsigned_i & half_sel[15]}}, half_sel};
            end
            default: begin
                merged_word_o = wdata_i;
                load_value_o  = word_i;
            end
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store initiator: one request at a time, word-aligned memory
// transactions, read-modify-write for sub-word stores, registered response.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_a,
    output logic [DATA_W-1:0] mem_wd,
    input  logic [DATA_W-1:0] mem_rd
);

    logic [1:0]        state_q,     state_d;
    logic              we_q,        we_d;
    logic [1:0]        size_q,      size_d;
    logic              uns_q,       uns_d;
    logic [ADDR_W-1:0] addr_q,      addr_d;
    logic [DATA_W-1:0] wdata_q,     wdata_d;
    logic [DATA_W-1:0] word_q,      word_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q,   rsp_err_d;

    logic              accept;
    logic              bad_req;
    logic              in_access;
    logic [DATA_W-1:0] lane_word;
    logic [DATA_W-1:0] merged_word;
    logic [DATA_W-1:0] load_value;

    assign req_ready = (state_q == ST_IDLE) && !reset;
    assign accept    = req_valid && req_ready;
    assign bad_req   = (req_size == SZ_ILL) || is_misaligned(req_size, req_addr[1:0]);

    // Loads extract straight from the live read data; stores merge into the captured word.
    assign lane_word = (state_q == ST_READ) ? mem_rd : word_q;

    lsu_lane_unit u_lane (
        .word_i        (lane_word),
        .wdata_i       (wdata_q),
        .size_i        (size_q),
        .offset_i      (addr_q[1:0]),
        .unsigned_i    (uns_q),
        .merged_word_o (merged_word),
        .load_value_o  (load_value)
    );

    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        size_d      = size_q;
        uns_d       = uns_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        word_d      = word_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    we_d        = req_we;
                    size_d      = req_size;
                    uns_d       = req_unsigned;
                    addr_d      = req_addr;
                    wdata_d     = req_wdata;
                    rsp_rdata_d = '0;
                    rsp_err_d   = bad_req;
                    if (bad_req)
                        state_d = ST_RESP;
                    else if (req_we && (req_size == SZ_WORD))
                        state_d = ST_WRITE;
                    else
                        state_d = ST_READ;
                end
            end
            ST_READ: begin
                word_d = mem_rd;
                if (we_q) begin
                    state_d = ST_WRITE;
                end else begin
                    rsp_rdata_d = load_value;
                    state_d     = ST_RESP;
                end
            end
            ST_WRITE: state_d = ST_RESP;
            default: begin
                rsp_rdata_d = '0;
                rsp_err_d   = 1'b0;
                state_d     = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            we_q        <= 1'b0;
            size_q      <= SZ_BYTE;
            uns_q       <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            word_q      <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignment so all flops update together.
            state_q     <= state_d;
            we_q        <= we_d;
            size_q      <= size_d;
            uns_q       <= uns_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            word_q      <= word_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // Memory controls are gated by reset so an aborted request never commits a write.
    assign in_access = ((state_q == ST_READ) || (state_q == ST_WRITE)) && !reset;
    assign mem_we    = (state_q == ST_WRITE) && !reset;
    assign mem_a     = in_access ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
    assign mem_wd    = mem_we ? ((size_q == SZ_WORD) ? wdata_q : merged_word) : '0;

    assign rsp_valid = (state_q == ST_RESP) && !reset;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed scoreboard bench for load_store_unit with a small behavioural word memory.
module tb_load_store_unit;
    import lsu_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        mem_we;
    logic [31:0] mem_a;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd;

    load_store_unit #(.DATA_W(32), .ADDR_W(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .mem_we       (mem_we),
        .mem_a        (mem_a),
        .mem_wd       (mem_wd),
        .mem_rd       (mem_rd)
    );

    always #5 clk = ~clk;

    // Word memory with a preload port used only while the DUT is idle.
    logic [31:0] mem [0:255];
    logic        pl_en = 1'b0;
    logic [7:0]  pl_idx = '0;
    logic [31:0] pl_data = '0;

    assign mem_rd = mem[mem_a[9:2]];

    always @(posedge clk) begin
        if (mem_we)
            mem[mem_a[9:2]] <= mem_wd;
        else if (pl_en)
            mem[pl_idx] <= pl_data;
    end

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    rsp_t exp_q[$];
    rsp_t got_q[$];

    int          wr_cnt = 0;
    int          rd_cnt = 0;
    int          a_cnt = 0;
    logic [31:0] last_wd = '0;
    logic [31:0] last_wa = '0;

    always @(negedge clk) begin
        if (rsp_valid)
            got_q.push_back({rsp_rdata, rsp_err});
        if (mem_we) begin
            wr_cnt++;
            last_wd = mem_wd;
            last_wa = mem_a;
        end
        if (mem_a != 32'd0) begin
            a_cnt++;
            if (!mem_we)
                rd_cnt++;
        end
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk);
        pl_en   = 1'b1;
        pl_idx  = addr[9:2];
        pl_data = data;
        @(posedge clk);
        #1 pl_en = 1'b0;
    endtask

    task automatic drive(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata);
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
    endtask

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, " ready"}, {31'd0, req_ready}, 32'd1);
    endtask

    task automatic compare_rsp(input string tag);
        rsp_t e;
        rsp_t g;
        if (got_q.size() == 0 || exp_q.size() == 0) begin
            check({tag, " rsp present"}, 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            check({tag, " rdata"}, g.rdata, e.rdata);
            check({tag, " err"}, {31'd0, g.err}, {31'd0, e.err});
        end
    endtask

    task automatic issue(input string tag, input logic we, input logic [1:0] size,
                         input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp_rdata, input logic exp_err,
                         input int exp_lat, input int exp_wr, input int exp_rd);
        int lat, w0, r0, a0;
        wait_ready(tag);
        w0 = wr_cnt;
        r0 = rd_cnt;
        a0 = a_cnt;
        drive(we, size, uns, addr, wdata);
        exp_q.push_back({exp_rdata, exp_err});
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!rsp_valid && lat < 10);
        check({tag, " latency"}, lat, exp_lat);
        #1;
        compare_rsp(tag);
        check({tag, " writes"}, wr_cnt - w0, exp_wr);
        check({tag, " reads"}, rd_cnt - r0, exp_rd);
        if (exp_err)
            check({tag, " mem_a idle"}, a_cnt - a0, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int w0;
        reset = 1'b1;
        preload(32'h40, 32'h8899AABB);
        preload(32'h20, 32'hCAFEF00D);
        preload(32'h80, 32'h00000000);

        // Reset state
        @(negedge clk);
        check("rst req_ready", {31'd0, req_ready}, 32'd0);
        check("rst rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst rsp_rdata", rsp_rdata, 32'd0);
        check("rst rsp_err",   {31'd0, rsp_err}, 32'd0);
        check("rst mem_we",    {31'd0, mem_we}, 32'd0);
        check("rst mem_a",     mem_a, 32'd0);
        check("rst mem_wd",    mem_wd, 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("post-rst req_ready", {31'd0, req_ready}, 32'd1);

        // Loads with sign/zero extension
        issue("ldb_s41", 1'b0, SZ_BYTE, 1'b0, 32'h41, 32'h0, 32'hFFFFFFAA, 1'b0, 2, 0, 1);
        issue("ldb_u41", 1'b0, SZ_BYTE, 1'b1, 32'h41, 32'h0, 32'h000000AA, 1'b0, 2, 0, 1);
        issue("ldh_s42", 1'b0, SZ_HALF, 1'b0, 32'h42, 32'h0, 32'hFFFF8899, 1'b0, 2, 0, 1);
        issue("ldh_u42", 1'b0, SZ_HALF, 1'b1, 32'h42, 32'h0, 32'h00008899, 1'b0, 2, 0, 1);
        issue("ldb_s40", 1'b0, SZ_BYTE, 1'b0, 32'h40, 32'h0, 32'hFFFFFFBB, 1'b0, 2, 0, 1);
        issue("ldb_s43", 1'b0, SZ_BYTE, 1'b0, 32'h43, 32'h0, 32'hFFFFFF88, 1'b0, 2, 0, 1);

        // Sub-word store via read-modify-write
        preload(32'h40, 32'h11223344);
        issue("stb42", 1'b1, SZ_BYTE, 1'b0, 32'h42, 32'h0000005C, 32'h0, 1'b0, 3, 1, 1);
        check("stb42 mem_wd", last_wd, 32'h115C3344);
        check("stb42 mem_a",  last_wa, 32'h00000040);
        check("stb42 memory", mem[8'h10], 32'h115C3344);

        // Word store then readback
        issue("stw80", 1'b1, SZ_WORD, 1'b0, 32'h80, 32'hDEADBEEF, 32'h0, 1'b0, 2, 1, 0);
        check("stw80 mem_wd", last_wd, 32'hDEADBEEF);
        check("stw80 mem_a",  last_wa, 32'h00000080);
        issue("ldw80", 1'b0, SZ_WORD, 1'b0, 32'h80, 32'h0, 32'hDEADBEEF, 1'b0, 2, 0, 1);

        // Upper-half store
        issue("sth82", 1'b1, SZ_HALF, 1'b0, 32'h82, 32'h0000BEEF, 32'h0, 1'b0, 3, 1, 1);
        check("sth82 mem_wd", last_wd, 32'hBEEFBEEF);

        // Error requests
        issue("ldh_mis43", 1'b0, SZ_HALF, 1'b0, 32'h43, 32'h0, 32'h0, 1'b1, 1, 0, 0);
        issue("ill_size",  1'b1, SZ_ILL,  1'b0, 32'h40, 32'hFFFFFFFF, 32'h0, 1'b1, 1, 0, 0);
        issue("ldw_mis82", 1'b0, SZ_WORD, 1'b0, 32'h82, 32'h0, 32'h0, 1'b1, 1, 0, 0);

        // Reset during the WRITE cycle of a halfword store
        wait_ready("abort");
        w0 = wr_cnt;
        drive(1'b1, SZ_HALF, 1'b0, 32'h22, 32'h00001234);
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        check("abort mem_we",    {31'd0, mem_we}, 32'd0);
        check("abort rsp_valid", {31'd0, rsp_valid}, 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("abort req_ready", {31'd0, req_ready}, 32'd1);
        repeat (3) @(negedge clk);
        check("abort memory", mem[8'h08], 32'hCAFEF00D);
        check("abort writes", wr_cnt - w0, 32'd0);
        check("abort no rsp", got_q.size(), 32'd0);

        // Back-to-back loads with req_valid held high
        wait_ready("b2b");
        drive(1'b0, SZ_WORD, 1'b0, 32'h80, 32'h0);
        exp_q.push_back({32'hBEEFBEEF, 1'b0});
        exp_q.push_back({32'hBEEFBEEF, 1'b0});
        @(negedge clk);
        check("b2b READ ready", {31'd0, req_ready}, 32'd0);
        @(negedge clk);
        check("b2b RESP ready", {31'd0, req_ready}, 32'd0);
        check("b2b RESP valid", {31'd0, rsp_valid}, 32'd1);
        @(negedge clk);
        check("b2b IDLE ready", {31'd0, req_ready}, 32'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        check("b2b READ2 ready", {31'd0, req_ready}, 32'd0);
        @(negedge clk);
        check("b2b RESP2 valid", {31'd0, rsp_valid}, 32'd1);
        #1;
        check("b2b rsp count", got_q.size(), 32'd2);
        compare_rsp("b2b first");
        compare_rsp("b2b second");

        repeat (3) @(negedge clk);
        check("final got empty", got_q.size(), 32'd0);
        check("final exp empty", exp_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
